tpu_tile_sched: RTL and testbench
=================================

TPU_TILE_SCHED -- requirements
Module: tpu_tile_sched

Interface
REQ-001 SHALL have parameter TILE_M, default 256: maximum rows (M) per issued tile.
REQ-002 SHALL have parameter TILE_N, default 64: maximum columns (N) per issued tile.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid/cmd_ready, in/out, 1 each: job-start handshake.
REQ-006 SHALL have ports cmd_K, cmd_M, cmd_N, input, 11/12/9: whole-job GEMM dimensions.
REQ-007 SHALL have ports tpu_in_valid, tpu_K, tpu_M, tpu_N, output, 1/11/12/9: start pulse and tile dimensions to the TPU.
REQ-008 SHALL have port tpu_busy, input, 1: TPU computing.
REQ-009 SHALL have ports tile_m_base, tile_n_base, output, 12/9: origin of the current tile in the job.
REQ-010 SHALL have ports tile_valid/tile_ready, out/in, 1 each: finished-tile handoff to host (drain C, reload A/B).
REQ-011 SHALL have ports rsp_valid/rsp_ready, out/in, 1 each, and rsp_tiles, output, 16: job completion and tile count.

Function
REQ-012 SHALL implement states IDLE, ISSUE, GUARD, WAIT, HANDOFF, DONE.
REQ-013 cmd_ready SHALL be 1 only in IDLE; job accepted on cmd_valid && cmd_ready, latching K/M/N and clearing bases and tile count.
REQ-014 If the accepted job has M==0 or N==0 or K==0, SHALL go IDLE->DONE with rsp_tiles=0 and never pulse tpu_in_valid.
REQ-015 Otherwise IDLE->ISSUE; ISSUE SHALL assert tpu_in_valid for exactly one cycle, then go to GUARD.
REQ-016 tpu_M SHALL be min(TILE_M, M - tile_m_base); tpu_N min(TILE_N, N - tile_n_base); tpu_K the latched K; all stable from ISSUE through HANDOFF.
REQ-017 GUARD SHALL last exactly one cycle (tpu_busy not sampled), then WAIT.
REQ-018 WAIT SHALL hold while tpu_busy=1; on tpu_busy=0 SHALL increment tile count and go HANDOFF.
REQ-019 HANDOFF SHALL hold tile_valid=1 until tile_ready=1; tile_ready SHALL be ignored outside HANDOFF.
REQ-020 On handoff: if tile_n_base+TILE_N < N, tile_n_base += TILE_N; else tile_n_base=0 and tile_m_base += TILE_M; then ISSUE, unless that was the last tile (both bases at final tile), then DONE.
REQ-021 Tile order SHALL be N inner, M outer; base arithmetic SHALL be wide enough that no wrap occurs for M=4095, N=511.
REQ-022 DONE SHALL hold rsp_valid=1 with rsp_tiles valid until rsp_ready=1, then IDLE; rsp_ready and tile_ready high together SHALL only affect the current state's handshake.
REQ-023 cmd_valid asserted outside IDLE SHALL be ignored (not queued).

Reset
REQ-024 On reset assertion SHALL enter IDLE immediately, including mid-tile; all outputs 0 except cmd_ready=1 once in IDLE.
REQ-025 Reset SHALL NOT be required to quiesce the TPU; a tpu_busy high after reset SHALL be ignored in IDLE.

Structure
REQ-026 State encoding and the dimension widths (K 11, M 12, N 9) SHALL live in a shared package tpu_pkg used with the TPU and CFU.
REQ-027 One sub-module tile_counter (base-advance and last-tile detect) is natural; otherwise a single FSM.

Verification
REQ-028 M=300,N=100,K=64 -> tiles (m_base,n_base,M,N)=(0,0,256,64),(0,64,256,36),(256,0,44,64),(256,64,44,36); rsp_tiles=4.
REQ-029 M=256,N=64,K=8 -> exactly one tpu_in_valid pulse, one tile (0,0,256,64), rsp_tiles=1.
REQ-030 N=0 -> no tpu_in_valid, rsp_valid next cycle, rsp_tiles=0.
REQ-031 tile_ready held low 20 cycles in HANDOFF -> no next ISSUE until tile_ready; rsp_ready held low 5 cycles -> rsp_valid held, cmd_ready=0.
REQ-032 reset asserted during WAIT of tile 2 -> same cycle outputs zero, cmd_ready=1; new job M=4,N=4 completes with rsp_tiles=1.
REQ-033 M=4095,N=511 -> 16x8=128 tiles, last tile (3840,448,255,63), rsp_tiles=128.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU, CFU and tile scheduler:
// GEMM dimension widths and the scheduler state encoding.
package tpu_pkg;

    localparam int unsigned K_W = 11;
    localparam int unsigned M_W = 12;
    localparam int unsigned N_W = 9;
    localparam int unsigned TILE_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        GUARD   = 3'd2,
        WAIT    = 3'd3,
        HANDOFF = 3'd4,
        DONE    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/tpu_tile_sched_tile_counter.sv
// Tile origin walker: N inner, M outer. Produces the clipped tile size
// for the current origin and flags the final tile of the job.
module tile_counter
    import tpu_pkg::*;
#(
    parameter int unsigned TILE_M = 256,
    parameter int unsigned TILE_N = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    input  logic [M_W-1:0] job_m,
    input  logic [N_W-1:0] job_n,
    output logic [M_W-1:0] m_base,
    output logic [N_W-1:0] n_base,
    output logic [M_W-1:0] tile_m,
    output logic [N_W-1:0] tile_n,
    output logic           last
);

    logic [M_W-1:0] m_base_q, m_base_d;
    logic [N_W-1:0] n_base_q, n_base_d;

    // One extra bit so base+TILE cannot wrap at M=4095 / N=511.
    logic [M_W:0]   m_next_wide;
    logic [N_W:0]   n_next_wide;
    logic [M_W-1:0] m_rem;
    logic [N_W-1:0] n_rem;
    logic           m_more;
    logic           n_more;

    always_comb begin
        m_next_wide = {1'b0, m_base_q} + (M_W+1)'(TILE_M);
        n_next_wide = {1'b0, n_base_q} + (N_W+1)'(TILE_N);
        m_more      = m_next_wide < {1'b0, job_m};
        n_more      = n_next_wide < {1'b0, job_n};
        last        = !m_more && !n_more;

        m_rem  = job_m - m_base_q;
        n_rem  = job_n - n_base_q;
        tile_m = ({1'b0, m_rem} > (M_W+1)'(TILE_M)) ? M_W'(TILE_M) : m_rem;
        tile_n = ({1'b0, n_rem} > (N_W+1)'(TILE_N)) ? N_W'(TILE_N) : n_rem;
    end

    always_comb begin
        m_base_d = m_base_q;
        n_base_d = n_base_q;
        if (clear) begin
            m_base_d = '0;
            n_base_d = '0;
        end else if (advance) begin
            if (last) begin
                m_base_d = '0;
                n_base_d = '0;
            end else if (n_more) begin
                n_base_d = n_next_wide[N_W-1:0];
            end else begin
                n_base_d = '0;
                m_base_d = m_next_wide[M_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_base_q <= '0;
            n_base_q <= '0;
        end else begin
            m_base_q <= m_base_d;
            n_base_q <= n_base_d;
        end
    end

    assign m_base = m_base_q;
    assign n_base = n_base_q;

endmodule

// File: rtl/tpu_tile_sched.sv
// Splits a GEMM job into TILE_M x TILE_N tiles, issues each to the TPU,
// waits for completion and hands every finished tile to the host.
module tpu_tile_sched
    import tpu_pkg::*;
#(
    parameter int unsigned TILE_M = 256,
    parameter int unsigned TILE_N = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [K_W-1:0]        cmd_K,
    input  logic [M_W-1:0]        cmd_M,
    input  logic [N_W-1:0]        cmd_N,
    output logic                  tpu_in_valid,
    output logic [K_W-1:0]        tpu_K,
    output logic [M_W-1:0]        tpu_M,
    output logic [N_W-1:0]        tpu_N,
    input  logic                  tpu_busy,
    output logic [M_W-1:0]        tile_m_base,
    output logic [N_W-1:0]        tile_n_base,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TILE_CNT_W-1:0] rsp_tiles
);

    sched_state_e          state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [M_W-1:0]        m_q, m_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [TILE_CNT_W-1:0] count_q, count_d;

    logic           tc_clear;
    logic           tc_advance;
    logic           tc_last;
    logic [M_W-1:0] tc_tile_m;
    logic [N_W-1:0] tc_tile_n;
    logic           tile_active;

    tile_counter #(
        .TILE_M (TILE_M),
        .TILE_N (TILE_N)
    ) u_tile_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (tc_clear),
        .advance (tc_advance),
        .job_m   (m_q),
        .job_n   (n_q),
        .m_base  (tile_m_base),
        .n_base  (tile_n_base),
        .tile_m  (tc_tile_m),
        .tile_n  (tc_tile_n),
        .last    (tc_last)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        m_d          = m_q;
        n_d          = n_q;
        count_d      = count_q;
        cmd_ready    = 1'b0;
        tpu_in_valid = 1'b0;
        tile_valid   = 1'b0;
        rsp_valid    = 1'b0;
        tc_clear     = 1'b0;
        tc_advance   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    k_d      = cmd_K;
                    m_d      = cmd_M;
                    n_d      = cmd_N;
                    count_d  = '0;
                    tc_clear = 1'b1;
                    if ((cmd_K == '0) || (cmd_M == '0) || (cmd_N == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tpu_in_valid = 1'b1;
                state_d      = GUARD;
            end
            // The TPU may not have raised busy yet; skip sampling it here.
            GUARD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tpu_busy) begin
                    count_d = count_q + TILE_CNT_W'(1);
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                tile_valid = 1'b1;
                if (tile_ready) begin
                    tc_advance = 1'b1;
                    state_d    = tc_last ? DONE : ISSUE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            n_q     <= n_d;
            count_q <= count_d;
        end
    end

    assign tile_active = (state_q == ISSUE) || (state_q == GUARD) ||
                         (state_q == WAIT)  || (state_q == HANDOFF);
    assign tpu_K       = tile_active ? k_q : '0;
    assign tpu_M       = tile_active ? tc_tile_m : '0;
    assign tpu_N       = tile_active ? tc_tile_n : '0;
    assign rsp_tiles   = (state_q == DONE) ? count_q : '0;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Scoreboard bench for tpu_tile_sched: expected tiles and responses are
// queued at job submission and checked by independent monitors.
module tb_tpu_tile_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_K;
    logic [11:0] cmd_M;
    logic [8:0]  cmd_N;
    logic        tpu_in_valid;
    logic [10:0] tpu_K;
    logic [11:0] tpu_M;
    logic [8:0]  tpu_N;
    logic        tpu_busy;
    logic [11:0] tile_m_base;
    logic [8:0]  tile_n_base;
    logic        tile_valid;
    logic        tile_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_tiles;

    tpu_tile_sched #(
        .TILE_M (256),
        .TILE_N (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_K        (cmd_K),
        .cmd_M        (cmd_M),
        .cmd_N        (cmd_N),
        .tpu_in_valid (tpu_in_valid),
        .tpu_K        (tpu_K),
        .tpu_M        (tpu_M),
        .tpu_N        (tpu_N),
        .tpu_busy     (tpu_busy),
        .tile_m_base  (tile_m_base),
        .tile_n_base  (tile_n_base),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_tiles    (rsp_tiles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mb;
        int nb;
        int m;
        int n;
        int k;
    } tile_t;

    tile_t tile_q[$];
    int    rsp_q[$];
    tile_t last_t;

    int compared   = 0;
    int mismatched = 0;
    int tiles_seen = 0;
    int rsp_done   = 0;
    int tile_stall = 0;
    int rsp_stall  = 0;
    int busy_len   = 6;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_tile(input int mb, input int nb, input int m, input int n, input int k);
        tile_t t;
        t.mb = mb; t.nb = nb; t.m = m; t.n = n; t.k = k;
        tile_q.push_back(t);
    endtask

    // TPU model: busy for a while after reset, then busy_len cycles per start pulse.
    initial begin
        tpu_busy = 1'b1;
        repeat (10) @(negedge clk);
        tpu_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tpu_in_valid) begin
                tpu_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tpu_busy = 1'b0;
            end
        end
    end

    // Tile monitor: each start pulse pops one expected tile.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tpu_in_valid) begin
                if (tile_q.size() == 0) begin
                    check("spurious_tile", tpu_in_valid, 0);
                end else begin
                    last_t = tile_q.pop_front();
                    check("tile_m_base", tile_m_base, last_t.mb);
                    check("tile_n_base", tile_n_base, last_t.nb);
                    check("tpu_M", tpu_M, last_t.m);
                    check("tpu_N", tpu_N, last_t.n);
                    check("tpu_K", tpu_K, last_t.k);
                end
                tiles_seen++;
            end
        end
    end

    // Response monitor: each new rsp_valid pops one expected tile count.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && !prev) begin
                if (rsp_q.size() == 0) check("spurious_rsp", rsp_valid, 0);
                else check("rsp_tiles", rsp_tiles, rsp_q.pop_front());
            end
            prev = rsp_valid;
        end
    end

    // Host tile sink with optional stall; the tile must be held meanwhile.
    initial begin
        int tw = 0;
        tile_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (tile_ready) begin
                tile_ready = 1'b0;
                tw = 0;
            end else if (tw > 0) begin
                check("tile_hold_valid", tile_valid, 1);
                check("tile_hold_no_issue", tpu_in_valid, 0);
                check("tile_hold_tpu_M", tpu_M, last_t.m);
                tw++;
                if (tw > tile_stall) tile_ready = 1'b1;
            end else if (tile_valid) begin
                tw = 1;
                if (tw > tile_stall) tile_ready = 1'b1;
            end
        end
    end

    // Host response sink with optional stall.
    initial begin
        int rw = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_ready) begin
                rsp_ready = 1'b0;
                rw = 0;
                rsp_done++;
            end else if (rw > 0) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_cmd_ready", cmd_ready, 0);
                rw++;
                if (rw > rsp_stall) rsp_ready = 1'b1;
            end else if (rsp_valid) begin
                rw = 1;
                if (rw > rsp_stall) rsp_ready = 1'b1;
            end
        end
    end

    task automatic send_job(input int m, input int n, input int k, input int extra);
        int budget = 0;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
        cmd_M = 12'(m); cmd_N = 9'(n); cmd_K = 11'(k);
        cmd_valid = 1'b1;
        @(negedge clk);
        // Distinct dimensions while busy must not be picked up.
        cmd_M = 12'd4; cmd_N = 9'd4; cmd_K = 11'd4;
        repeat (extra) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int c = 0;
        while (rsp_done < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (rsp_done < target) check("rsp_timeout", rsp_done, target);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_tpu_in_valid"}, tpu_in_valid, 0);
        check({tag, "_tpu_M"}, tpu_M, 0);
        check({tag, "_tpu_N"}, tpu_N, 0);
        check({tag, "_tpu_K"}, tpu_K, 0);
        check({tag, "_tile_valid"}, tile_valid, 0);
        check({tag, "_tile_m_base"}, tile_m_base, 0);
        check({tag, "_tile_n_base"}, tile_n_base, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_tiles"}, rsp_tiles, 0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_M = '0; cmd_N = '0; cmd_K = '0;
        #1;
        check_idle_outputs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // TPU model still reports busy here; scheduler must stay idle.
        repeat (3) @(negedge clk);
        check_idle_outputs("busy_after_rst");

        // 300x100: four clipped tiles; cmd_valid held into the job.
        push_tile(0, 0, 256, 64, 64);
        push_tile(0, 64, 256, 36, 64);
        push_tile(256, 0, 44, 64, 64);
        push_tile(256, 64, 44, 36, 64);
        rsp_q.push_back(4);
        send_job(300, 100, 64, 5);
        wait_rsp(1, 500);

        // Exact single tile, with host stalls on tile and response.
        tile_stall = 20;
        rsp_stall  = 5;
        push_tile(0, 0, 256, 64, 8);
        rsp_q.push_back(1);
        send_job(256, 64, 8, 0);
        wait_rsp(2, 500);
        tile_stall = 0;
        rsp_stall  = 0;

        // Degenerate jobs complete immediately with zero tiles.
        rsp_q.push_back(0);
        send_job(10, 0, 5, 0);
        check("zero_n_rsp_next", rsp_valid, 1);
        wait_rsp(3, 50);
        rsp_q.push_back(0);
        send_job(10, 10, 0, 0);
        check("zero_k_rsp_next", rsp_valid, 1);
        wait_rsp(4, 50);

        // Reset while the second tile is in WAIT.
        base = tiles_seen;
        push_tile(0, 0, 256, 64, 64);
        push_tile(0, 64, 256, 36, 64);
        push_tile(256, 0, 44, 64, 64);
        push_tile(256, 64, 44, 36, 64);
        rsp_q.push_back(4);
        send_job(300, 100, 64, 0);
        for (int i = 0; i < 200 && tiles_seen < base + 2; i++) @(negedge clk);
        check("reached_tile2", tiles_seen, base + 2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        tile_q.delete();
        rsp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        push_tile(0, 0, 4, 4, 16);
        rsp_q.push_back(1);
        send_job(4, 4, 16, 0);
        wait_rsp(5, 200);

        // Largest job: 16 x 8 tiles, last one clipped to 255 x 63.
        for (int mb = 0; mb < 4095; mb += 256) begin
            for (int nb = 0; nb < 511; nb += 64) begin
                push_tile(mb, nb, (4095 - mb > 256) ? 256 : 4095 - mb,
                          (511 - nb > 64) ? 64 : 511 - nb, 2047);
            end
        end
        rsp_q.push_back(128);
        send_job(4095, 511, 2047, 0);
        wait_rsp(6, 5000);
        check("last_tile_m_base", last_t.mb, 3840);
        check("last_tile_n_base", last_t.nb, 448);

        repeat (3) @(negedge clk);
        check_idle_outputs("end");
        check("tile_q_drained", tile_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
